// File: rtl/noc_output_arb_if.sv
// Request/response bundle between NUM_IN requesters, the output arbiter and
// the downstream consumer of the merged packet stream.
interface noc_output_arb_if #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 57,
  parameter int DEPTH  = 2
);
  localparam int IDX_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic                    out_ready;
  logic [IDX_W-1:0]        grant_idx;
  logic [CNT_W-1:0]        fifo_count;

  // Requesters and downstream consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, grant_idx, fifo_count
  );

  // Arbiter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, grant_idx, fifo_count
  );
endinterface

// File: rtl/noc_output_arb.sv
// Router output-port arbiter: round-robin or fixed-priority selection of one
// input channel per cycle into a small FIFO that absorbs downstream stalls.
module noc_output_arb #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 57,
  parameter int DEPTH  = 2,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  noc_output_arb_if.slave   bus
);
  localparam int IDX_W = $clog2(NUM_IN);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(NUM_IN);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_IN - 1);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  winner;
  logic              found;
  logic [IDX_W:0]    idx_ext;
  logic [NUM_IN-1:0] ready;
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  push_data;
  logic [WIDTH-1:0]  head_q;
  logic [WIDTH-1:0]  head_next;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_inc;
  logic [CNT_W-1:0]  count;
  logic [WIDTH-1:0]  mem [DEPTH];

  // Arbitration: pick one requester from in_valid and rr_ptr.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    idx_ext = '0;
    if (MODE == 1) begin
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        if (bus.in_valid[k]) begin
          winner = IDX_W'(k);
          found  = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        idx_ext = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (idx_ext >= N_EXT) idx_ext = idx_ext - N_EXT;
        if (!found && bus.in_valid[idx_ext[IDX_W-1:0]]) begin
          winner = idx_ext[IDX_W-1:0];
          found  = 1'b1;
        end
      end
    end
  end

  // Acceptance uses the pre-pop count, so a full FIFO never passes data through.
  always_comb begin
    ready = '0;
    if (!reset && found && (count < FULL)) ready[winner] = 1'b1;
  end

  always_comb begin
    push_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (winner == IDX_W'(k)) push_data = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  assign push   = |ready;
  assign pop    = (count != '0) && bus.out_ready;
  assign rd_inc = rd_ptr + PTR_W'(1);

  // Registered head: follows the FIFO front, holds its last value when empty.
  always_comb begin
    head_next = head_q;
    if (pop) begin
      if (count == CNT_W'(1)) begin
        if (push) head_next = push_data;
      end else begin
        head_next = mem[rd_inc];
      end
    end else if (push && (count == '0)) begin
      head_next = push_data;
    end
  end

  // FIFO storage: contents are never cleared, reset only invalidates them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Control state and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      grant_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      head_q  <= '0;
    end else begin
      if (push) begin
        rr_ptr  <= (winner == LAST) ? '0 : winner + IDX_W'(1);
        grant_q <= winner;
        wr_ptr  <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_inc;
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
      head_q <= head_next;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = (count != '0);
  assign bus.out_data   = head_q;
  assign bus.grant_idx  = grant_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_noc_output_arb.sv
// Bench for noc_output_arb: one round-robin and one fixed-priority instance
// share stimulus; a reference model with packet queues tracks both.
module tb_noc_output_arb;
  localparam int NUM_IN = 4;
  localparam int WIDTH  = 57;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset;
  logic [NUM_IN-1:0]       in_valid;
  logic [WIDTH-1:0]        pkt_in [NUM_IN];
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_ready;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = pkt_in[i];
  end

  noc_output_arb_if #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .DEPTH(DEPTH)) b0 ();
  noc_output_arb_if #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .DEPTH(DEPTH)) b1 ();

  assign b0.in_valid  = in_valid;
  assign b0.in_data   = in_data;
  assign b0.out_ready = out_ready;
  assign b1.in_valid  = in_valid;
  assign b1.in_data   = in_data;
  assign b1.out_ready = out_ready;

  noc_output_arb #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  noc_output_arb #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state, index 0 = round-robin DUT, 1 = fixed-priority DUT.
  int             m_cnt [2];
  logic [1:0]     m_rr  [2];
  logic [1:0]     m_gr  [2];
  bit             known = 1'b0;
  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];
  bit  sat_out   = 1'b0;
  bit  sat_bump  = 1'b0;
  int  sat_next  = 0;
  int  sat_grants = 0;

  function automatic logic [1:0] pick(input int m);
    logic [1:0] idx;
    pick = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = (m == 1) ? 2'(k) : m_rr[0] + 2'(k);
      if (in_valid[idx]) pick = idx;
    end
  endfunction

  function automatic logic [3:0] o_ready(input int m);
    return (m == 0) ? b0.in_ready : b1.in_ready;
  endfunction
  function automatic logic o_valid(input int m);
    return (m == 0) ? b0.out_valid : b1.out_valid;
  endfunction
  function automatic logic [WIDTH-1:0] o_data(input int m);
    return (m == 0) ? b0.out_data : b1.out_data;
  endfunction
  function automatic logic [1:0] o_count(input int m);
    return (m == 0) ? b0.fifo_count : b1.fifo_count;
  endfunction
  function automatic logic [1:0] o_grant(input int m);
    return (m == 0) ? b0.grant_idx : b1.grant_idx;
  endfunction

  function automatic logic [WIDTH-1:0] qpop(input int m);
    logic [WIDTH-1:0] d;
    d = '0;
    if (m == 0) begin
      if (q0.size() != 0) d = q0.pop_front();
    end else begin
      if (q1.size() != 0) d = q1.pop_front();
    end
    return d;
  endfunction

  // One clock: check outputs at the falling edge, update the model at the rising edge.
  task automatic cyc();
    logic [3:0]       er;
    logic [1:0]       wn [2];
    bit               pu [2];
    bit               po [2];
    logic [WIDTH-1:0] d;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      wn[m] = pick(m);
      pu[m] = 1'b0;
      po[m] = 1'b0;
      er    = '0;
      if (!reset && (in_valid != '0) && (m_cnt[m] < DEPTH)) begin
        er[wn[m]] = 1'b1;
        pu[m]     = 1'b1;
      end
      check($sformatf("in_ready%0d", m), o_ready(m), er);
      if (known) begin
        check($sformatf("fifo_count%0d", m), o_count(m), m_cnt[m]);
        check($sformatf("out_valid%0d", m), o_valid(m), m_cnt[m] != 0);
        check($sformatf("grant_idx%0d", m), o_grant(m), m_gr[m]);
        if (m_cnt[m] != 0 && out_ready && !reset) begin
          po[m] = 1'b1;
          d = qpop(m);
          check($sformatf("out_data%0d", m), o_data(m), d);
          if (m == 0 && sat_out) begin
            check("sat_seq", o_data(0), sat_next);
            sat_next++;
          end
        end
      end
    end
    if (known) begin
      check("rr_ptr0", dut0.rr_ptr, m_rr[0]);
      check("rr_ptr1", dut1.rr_ptr, m_rr[1]);
    end
    @(posedge clk);
    if (reset) begin
      known = 1'b1;
      for (int m = 0; m < 2; m++) begin
        m_cnt[m] = 0;
        m_rr[m]  = 2'd0;
        m_gr[m]  = 2'd0;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (pu[m]) begin
          if (m == 0) q0.push_back(pkt_in[wn[m]]);
          else        q1.push_back(pkt_in[wn[m]]);
          m_rr[m] = wn[m] + 2'd1;
          m_gr[m] = wn[m];
        end
        m_cnt[m] = m_cnt[m] + int'(pu[m]) - int'(po[m]);
      end
    end
    #1;
    if (sat_bump && pu[0] && !reset) begin
      check("sat_grant", b0.grant_idx, sat_grants % 4);
      sat_grants++;
      pkt_in[wn[0]] = pkt_in[wn[0]] + WIDTH'(4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_IN; i++) pkt_in[i] = WIDTH'(32'hA0 + i);

    // Reset held for two edges with every input requesting.
    repeat (2) cyc();
    check("rst_ready", b0.in_ready, 4'b0000);
    check("rst_valid", b0.out_valid, 1'b0);
    check("rst_data",  b0.out_data, '0);
    check("rst_count", b0.fifo_count, 2'd0);
    check("rst_grant", b0.grant_idx, 2'd0);
    check("rst_ready1", b1.in_ready, 4'b0000);
    reset = 1'b0;

    // Round-robin saturation.
    for (int i = 0; i < NUM_IN; i++) pkt_in[i] = WIDTH'(i);
    sat_out  = 1'b1;
    sat_bump = 1'b1;
    repeat (20) cyc();
    sat_bump = 1'b0;
    in_valid = 4'b0000;
    repeat (3) cyc();
    sat_out = 1'b0;
    check("sat_total", sat_next, 20);

    // Sparse request from input 2.
    check("sparse_rr0", dut0.rr_ptr, 2'd0);
    in_valid  = 4'b0100;
    pkt_in[2] = WIDTH'(32'h2A);
    #1;
    check("sparse_ready", b0.in_ready, 4'b0100);
    cyc();
    in_valid = 4'b0000;
    check("sparse_valid", b0.out_valid, 1'b1);
    check("sparse_data",  b0.out_data, 64'h2A);
    check("sparse_rr",    dut0.rr_ptr, 2'd3);
    check("sparse_grant", b0.grant_idx, 2'd2);
    repeat (2) cyc();

    // Back-pressure from a clean pointer state.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < NUM_IN; i++) pkt_in[i] = WIDTH'(32'h100 + i);
    in_valid  = 4'hF;
    out_ready = 1'b0;
    repeat (2) cyc();
    #1;
    check("bp_ready", b0.in_ready, 4'b0000);
    check("bp_count", b0.fifo_count, 2'd2);
    cyc();
    out_ready = 1'b1;
    #1;
    check("bp_nopass", b0.in_ready, 4'b0000);
    cyc();
    #1;
    check("bp_ready2", b0.in_ready, 4'b0100);
    check("bp_head",   b0.out_data, 64'h101);
    cyc();
    check("bp_grant", b0.grant_idx, 2'd2);
    in_valid = 4'b0000;
    repeat (3) cyc();

    // Fixed priority: input 1 beats input 3 while it requests.
    pkt_in[1] = WIDTH'(32'h11);
    pkt_in[3] = WIDTH'(32'h33);
    in_valid  = 4'b1010;
    repeat (4) begin
      #1;
      check("fp_ready", b1.in_ready, 4'b0010);
      cyc();
      check("fp_grant", b1.grant_idx, 2'd1);
    end
    in_valid = 4'b1000;
    #1;
    check("fp_ready3", b1.in_ready, 4'b1000);
    cyc();
    check("fp_grant3", b1.grant_idx, 2'd3);
    check("fp_rr",     dut1.rr_ptr, 2'd0);
    in_valid = 4'b0000;
    repeat (3) cyc();

    // Reset while the FIFO holds two stalled entries.
    out_ready = 1'b0;
    in_valid  = 4'hF;
    repeat (2) cyc();
    in_valid = 4'b0000;
    check("mr_pre_count", b0.fifo_count, 2'd2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mr_valid", b0.out_valid, 1'b0);
    check("mr_count", b0.fifo_count, 2'd0);
    check("mr_rr",    dut0.rr_ptr, 2'd0);
    check("mr_rr1",   dut1.rr_ptr, 2'd0);
    out_ready = 1'b1;
    repeat (3) cyc();
    check("mr_stale", b0.out_valid, 1'b0);
    pkt_in[0] = WIDTH'(32'h5A);
    in_valid  = 4'b0001;
    cyc();
    in_valid = 4'b0000;
    check("mr_new_valid", b0.out_valid, 1'b1);
    check("mr_new_data",  b0.out_data, 64'h5A);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/noc_output_arb.md
# noc_output_arb

Parametrised, clocked output-port arbiter for the NoC router. It merges `NUM_IN` input channels of `WIDTH`-bit packets onto one output channel. Round-robin or fixed-priority arbitration feeds a small output FIFO that absorbs downstream back-pressure. It replaces the fixed 4-input output-control gate in each router output port.

## Interface
- `NUM_IN`, default 4: number of input channels; must be ≥2.
- `WIDTH`, default 57: packet width in bits.
- `DEPTH`, default 2: output FIFO depth; must be a power of two and ≥2.
- `MODE`, default 0: 0 = round-robin; 1 = fixed priority, where the lowest index wins.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  `NUM_IN`: per-input request; bit i belongs to channel i.
- `in_data`  in  `NUM_IN*WIDTH`: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_ready`  out  `NUM_IN`: per-input accept; at most one bit is high.
- `out_valid`  out  1: the FIFO head is valid.
- `out_data`  out  `WIDTH`: the FIFO head packet.
- `out_ready`  in  1: the downstream consumer accepts the head.
- `grant_idx`  out  `$clog2(NUM_IN)`: index of the last accepted input (registered).
- `fifo_count`  out  `$clog2(DEPTH)+1`: current FIFO occupancy.

## Operation
- **Transfer rules**
  - Input transfer: `in_valid[i] & in_ready[i]` on a rising edge.
  - Output transfer: `out_valid & out_ready` on a rising edge.
- **Arbitration** (combinational from `in_valid`, `rr_ptr`, `fifo_count`)
  - `MODE=0`: the winner is the first requesting index at or after `rr_ptr`, scanning upward modulo `NUM_IN`.
  - `MODE=1`: the winner is the lowest requesting index. `rr_ptr` is ignored but still maintained.
  - `in_ready[winner]=1` only when `fifo_count < DEPTH`. All other `in_ready` bits are 0.
  - When nothing is requesting or the FIFO is full, `in_ready` is 0.
- **Pointer update**
  - On an input transfer from channel w: `rr_ptr <= (w+1) mod NUM_IN` and `grant_idx <= w`.
  - With no transfer, both hold their values.
- **FIFO**
  - Circular buffer with `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits; both wrap naturally.
  - Push on an input transfer; pop on an output transfer.
  - `out_valid = (fifo_count != 0)`; `out_data` = the entry at `rd_ptr`.
  - Simultaneous push and pop: `fifo_count` is unchanged and both pointers advance.
  - Full with pop in the same cycle: no push is accepted. `in_ready` is evaluated on the pre-pop count, with no pass-through.
  - Empty: `out_data` holds its last value, and consumers must ignore it. There is no bypass, so an empty FIFO never presents a same-cycle input.
- **Assumption on inputs**: `in_valid` must not depend on `in_ready`. A requester holds `in_valid` and data stable until its transfer; the block does not check this.

## Timing
- **Reset** (`reset=1` at an edge): `rr_ptr=0`, `grant_idx=0`, `wr_ptr=rd_ptr=0`, `fifo_count=0`, `out_valid=0`, `out_data=0`.
  - `in_ready` is forced to 0 while `reset` is high.
  - FIFO contents are discarded.
  - Reset mid-operation takes priority over a concurrent push or pop.
- **Latency**: a packet accepted at edge t is presented on `out_data` with `out_valid=1` after edge t (visible in cycle t+1), provided it is at the FIFO head.
- **Throughput**: one packet per cycle sustained when `out_ready=1`.
- **Fairness**: in round-robin mode, a continuously requesting input is granted within `NUM_IN` transfers.
- **Back-pressure**: with `out_ready=0`, exactly `DEPTH` packets are accepted, then `in_ready` is all 0 until a pop occurs.

## Test plan
- **Reset**: hold `reset` for 2 cycles with all inputs valid. Required: `in_ready=0000`, `out_valid=0`, `out_data=0`, `fifo_count=0`, `grant_idx=0`.
- **Round-robin saturation** (`MODE=0`, `NUM_IN=4`, `out_ready=1`): input i drives `count+i`, incrementing by 4 per grant. Required: outputs 0,1,2,3,4,5,… one per cycle, the first in the cycle after the first accept; `grant_idx` cycles 0,1,2,3.
- **Sparse request**: `rr_ptr=0`, only input 2 valid with data `0x2A`. Required: `in_ready=0100` in the same cycle; the next cycle `out_data=0x2A`; `rr_ptr=3`, `grant_idx=2`.
- **Back-pressure** (`DEPTH=2`): all inputs valid, `out_ready=0`. Required: two accepts (inputs 0 and 1), then `in_ready=0000` and `fifo_count=2`. Raise `out_ready`: packets drain in order, and input 2 is accepted in the cycle after the first pop.
- **Fixed priority** (`MODE=1`): inputs 1 and 3 valid continuously. Required: only input 1 is granted while it is valid. Drop input 1: input 3 is granted the next cycle.
- **Reset mid-operation**: FIFO holds 2 entries and `out_ready=0`; assert `reset` for 1 cycle. Required: `out_valid=0` and `fifo_count=0` after the edge, the stale entries are never output, and `rr_ptr=0`.
